// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared state/grant encodings and control-line constants for the RTC bus scheduler
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'd0,
    GRANT_INIT  = 2'd1,
    GRANT_WRITE = 2'd2,
    GRANT_READ  = 2'd3
  } grant_e;

  localparam int A_D = 3;
  localparam int CS  = 2;
  localparam int RD  = 1;
  localparam int WR  = 0;

  localparam int         CNT_W        = 12;
  localparam logic [3:0] RTC_CTL_IDLE = 4'b1111;

  function automatic grant_e grant_of(input state_e s);
    case (s)
      ST_INIT:  return GRANT_INIT;
      ST_WRITE: return GRANT_WRITE;
      ST_READ:  return GRANT_READ;
      default:  return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_ctl_mux.sv
// rtl/rtc_ctl_mux.sv - selects the granted client's {a_d,cs,rd,wr}; idle lines when nobody holds the bus
module rtc_ctl_mux
  import rtc_pkg::*;
(
  input  grant_e     grant_i,
  input  logic [3:0] init_ctl_i,
  input  logic [3:0] esc_ctl_i,
  input  logic [3:0] lec_ctl_i,
  output logic [3:0] ctl_o
);

  always_comb begin
    ctl_o = RTC_CTL_IDLE;
    case (grant_i)
      GRANT_INIT:  ctl_o = init_ctl_i;
      GRANT_WRITE: ctl_o = esc_ctl_i;
      GRANT_READ:  ctl_o = lec_ctl_i;
      default:     ctl_o = RTC_CTL_IDLE;
    endcase
  end

endmodule

// File: rtl/rtc_bus_sched.sv
// rtl/rtc_bus_sched.sv - RTC bus scheduler: init burst, then arbitrated write/read bursts with guard gaps
// RTC_SCHED_AUTOREFRESH_EN adds a periodic internal read request every READ_PERIOD cycles.
module rtc_bus_sched
  import rtc_pkg::*;
#(
  parameter int INIT_CYCLES  = 518,
  parameter int WRITE_CYCLES = 90,
  parameter int READ_CYCLES  = 90,
  parameter int GAP_CYCLES   = 4,
  parameter int READ_PERIOD  = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_write,
  input  logic       req_read,
  input  logic [3:0] init_ctl,
  input  logic [3:0] esc_ctl,
  input  logic [3:0] lec_ctl,
  output logic       do_it_inic,
  output logic       do_it_esc,
  output logic       do_it_lec,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [1:0] grant,
  output logic       busy,
  output logic       init_done,
  output logic       write_ack,
  output logic       overrun
);

  if (INIT_CYCLES < 1 || INIT_CYCLES > 4095 || WRITE_CYCLES < 1 || WRITE_CYCLES > 4095 ||
      READ_CYCLES < 1 || READ_CYCLES > 4095 || GAP_CYCLES < 1 || GAP_CYCLES > 4095 ||
      READ_PERIOD < 1 || READ_PERIOD > 65536) begin : g_param_check
    $error("rtc_bus_sched: cycle parameter out of range");
  end

  localparam logic [CNT_W-1:0] INIT_LAST  = 12'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = 12'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = 12'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = 12'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_w_q, pend_w_d, pend_r_q, pend_r_d;
  logic               last_rd_q, last_rd_d;
  logic               done_q, done_d;
  logic               pick_w, pick_r, wr_entry, rd_entry;
  logic               refresh_pulse, rd_req;
  grant_e             grant_s;
  logic [3:0]         pins;

`ifdef RTC_SCHED_AUTOREFRESH_EN
  localparam logic [15:0] PERIOD_LAST = 16'(READ_PERIOD - 1);
  logic [15:0] tmr_q, tmr_d;

  assign refresh_pulse = done_q && (tmr_q == PERIOD_LAST);

  always_comb begin
    tmr_d = tmr_q;
    if (done_q) tmr_d = refresh_pulse ? 16'd0 : tmr_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmr_q <= 16'd0;
    else        tmr_q <= tmr_d;
  end
`else
  assign refresh_pulse = 1'b0;
`endif

  assign rd_req = req_read | refresh_pulse;

  // Alternate on contention; last_rd_q resets to 1 so write wins the first tie.
  assign pick_w = done_q & pend_w_q & (~pend_r_q | last_rd_q);
  assign pick_r = done_q & pend_r_q & ~pick_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    done_d  = done_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
      ST_INIT: if (cnt_q == INIT_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
      ST_WRITE: if (cnt_q == WRITE_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_READ: if (cnt_q == READ_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = pick_w ? ST_WRITE : (pick_r ? ST_READ : ST_IDLE);
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_w)      state_d = ST_WRITE;
        else if (pick_r) state_d = ST_READ;
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign wr_entry  = (state_d == ST_WRITE) && (state_q != ST_WRITE);
  assign rd_entry  = (state_d == ST_READ) && (state_q != ST_READ);
  assign pend_w_d  = (pend_w_q & ~wr_entry) | req_write;
  assign pend_r_d  = (pend_r_q & ~rd_entry) | rd_req;
  assign last_rd_d = wr_entry ? 1'b0 : (rd_entry ? 1'b1 : last_rd_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      cnt_q     <= '0;
      pend_w_q  <= 1'b0;
      pend_r_q  <= 1'b0;
      last_rd_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_w_q  <= pend_w_d;
      pend_r_q  <= pend_r_d;
      last_rd_q <= last_rd_d;
      done_q    <= done_d;
    end
  end

  assign do_it_inic = (state_q == ST_INIT);
  assign do_it_esc  = (state_q == ST_WRITE);
  assign do_it_lec  = (state_q == ST_READ);
  assign busy       = (state_q != ST_BOOT) && (state_q != ST_IDLE);
  assign init_done  = done_q;
  assign write_ack  = (state_q == ST_WRITE) && (cnt_q == WRITE_LAST);
  assign overrun    = rd_req & pend_r_q & ~rd_entry;
  assign grant_s    = grant_of(state_q);
  assign grant      = grant_s;

  rtc_ctl_mux u_ctl_mux (
    .grant_i    (grant_s),
    .init_ctl_i (init_ctl),
    .esc_ctl_i  (esc_ctl),
    .lec_ctl_i  (lec_ctl),
    .ctl_o      (pins)
  );

  assign a_d = pins[A_D];
  assign cs  = pins[CS];
  assign rd  = pins[RD];
  assign wr  = pins[WR];

endmodule

// File: tb/tb_rtc_bus_sched.sv
// tb/tb_rtc_bus_sched.sv - directed self-checking bench for rtc_bus_sched (INIT=20 WRITE=10 READ=8 GAP=2)
module tb_rtc_bus_sched;

  localparam logic [3:0] INIT_CTL = 4'b0101;
  localparam logic [3:0] ESC_CTL  = 4'b0011;
  localparam logic [3:0] LEC_CTL  = 4'b1000;
  localparam int K_IDLE = 0, K_INIT = 1, K_WRITE = 2, K_READ = 3, K_GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_write = 1'b0;
  logic       req_read = 1'b0;
  logic [3:0] init_ctl = INIT_CTL;
  logic [3:0] esc_ctl = ESC_CTL;
  logic [3:0] lec_ctl = LEC_CTL;
  logic       do_it_inic, do_it_esc, do_it_lec;
  logic       a_d, cs, rd, wr;
  logic [1:0] grant;
  logic       busy, init_done, write_ack, overrun;

  int checks = 0;
  int errors = 0;
  int rise [3];
  int n_rise = 0;
  logic prev_lec = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_sched #(
    .INIT_CYCLES  (20),
    .WRITE_CYCLES (10),
    .READ_CYCLES  (8),
    .GAP_CYCLES   (2),
    .READ_PERIOD  (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_write  (req_write),
    .req_read   (req_read),
    .init_ctl   (init_ctl),
    .esc_ctl    (esc_ctl),
    .lec_ctl    (lec_ctl),
    .do_it_inic (do_it_inic),
    .do_it_esc  (do_it_esc),
    .do_it_lec  (do_it_lec),
    .a_d        (a_d),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .grant      (grant),
    .busy       (busy),
    .init_done  (init_done),
    .write_ack  (write_ack),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [12:0] obs_vec();
    return {do_it_inic, do_it_esc, do_it_lec, grant, busy, init_done, write_ack, overrun, a_d, cs, rd, wr};
  endfunction

  // Vector order: {inic,esc,lec,grant[1:0],busy,init_done,write_ack,overrun,a_d,cs,rd,wr}.
  task automatic phase(input string tag, input int kind, input int n, input logic idone,
                       input logic [31:0] wr_mask = 32'h0, input logic [31:0] rd_mask = 32'h0,
                       input logic [31:0] ov_mask = 32'h0);
    logic [12:0] exp;
    for (int i = 0; i < n; i++) begin
      req_write = wr_mask[i];
      req_read  = rd_mask[i];
      #1;
      case (kind)
        K_INIT:  exp = {3'b100, 2'd1, 1'b1, idone, 1'b0, ov_mask[i], INIT_CTL};
        K_WRITE: exp = {3'b010, 2'd2, 1'b1, idone, 1'(i == n - 1), ov_mask[i], ESC_CTL};
        K_READ:  exp = {3'b001, 2'd3, 1'b1, idone, 1'b0, ov_mask[i], LEC_CTL};
        K_GAP:   exp = {3'b000, 2'd0, 1'b1, idone, 1'b0, ov_mask[i], 4'hF};
        default: exp = {3'b000, 2'd0, 1'b0, idone, 1'b0, ov_mask[i], 4'hF};
      endcase
      chk(tag, i, 32'(obs_vec()), 32'(exp));
      @(negedge clk);
    end
    req_write = 1'b0;
    req_read  = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    phase("reset", K_IDLE, 2, 1'b0);
    reset = 1'b1;
    phase("boot", K_IDLE, 1, 1'b0);
`ifdef RTC_SCHED_AUTOREFRESH_EN
    phase("init", K_INIT, 20, 1'b0);
    for (int c = 0; c < 330; c++) begin
      #1;
      chk("ar_overrun", c, 32'(overrun), 32'd0);
      if (do_it_lec && !prev_lec) begin
        if (n_rise < 3) rise[n_rise] = c;
        n_rise++;
      end
      prev_lec = do_it_lec;
      @(negedge clk);
    end
    chk("ar_rises", 0, n_rise, 3);
    chk("ar_first", 0, rise[0], 101);
    chk("ar_space", 1, rise[1] - rise[0], 100);
    chk("ar_space", 2, rise[2] - rise[1], 100);
`else
    phase("init", K_INIT, 20, 1'b0, 32'h20);
    phase("gap_i", K_GAP, 2, 1'b1);
    phase("write_a", K_WRITE, 10, 1'b1);
    phase("gap_a", K_GAP, 2, 1'b1);
    phase("idle_a", K_IDLE, 2, 1'b1, 32'h1);
    phase("write_b", K_WRITE, 10, 1'b1, 32'h0, 32'h54, 32'h50);
    phase("gap_b", K_GAP, 2, 1'b1);
    phase("read_b", K_READ, 8, 1'b1);
    phase("gap_b2", K_GAP, 2, 1'b1);
    phase("idle_b", K_IDLE, 2, 1'b1);
    phase("idle_c", K_IDLE, 2, 1'b1, 32'h1, 32'h1);
    phase("write_c", K_WRITE, 10, 1'b1);
    phase("gap_c", K_GAP, 2, 1'b1);
    phase("read_c", K_READ, 8, 1'b1);
    phase("gap_c2", K_GAP, 2, 1'b1);
    phase("idle_d", K_IDLE, 2, 1'b1, 32'h0, 32'h1);
    phase("read_d", K_READ, 4, 1'b1, 32'h2);
    reset = 1'b0;
    phase("rst_mid", K_IDLE, 2, 1'b0);
    reset = 1'b1;
    phase("boot2", K_IDLE, 1, 1'b0);
    phase("init2", K_INIT, 20, 1'b0);
    phase("gap_i2", K_GAP, 2, 1'b1);
    phase("idle_e", K_IDLE, 4, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
